// File: rtl/datamemory_pipelined.sv
// Pipelined data memory: registered instruction-fetch port plus a handshaked
// data port with byte-enable stores, configurable latency and fault reporting.
module datamemory_pipelined #(
    parameter int ADDR_WIDTH   = 32,
    parameter int INDEX_WIDTH  = 12,
    parameter int DEPTH        = 2**INDEX_WIDTH,
    parameter int WIDTH        = 32,
    parameter int DATA_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  instrReq,
    input  logic [ADDR_WIDTH-1:0] instrAddr,
    output logic [WIDTH-1:0]      instrOut,
    output logic                  instrValid,
    input  logic                  dataReq,
    output logic                  dataReady,
    input  logic                  dataWrite,
    input  logic [3:0]            dataByteEn,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [WIDTH-1:0]      dataIn,
    output logic [WIDTH-1:0]      dataOut,
    output logic                  dataValid,
    output logic                  dataError
);

    localparam logic [3:0] LAT_M1 = 4'(DATA_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_COMPLETE
    } state_t;

    logic [WIDTH-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                  req_write_q, req_write_d;
    logic [3:0]            req_be_q, req_be_d;
    logic [WIDTH-1:0]      req_wdata_q, req_wdata_d;
    logic [WIDTH-1:0]      data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic                  data_error_q, data_error_d;
    logic [WIDTH-1:0]      instr_out_q, instr_out_d;
    logic                  instr_valid_q, instr_valid_d;

    logic [INDEX_WIDTH-1:0] req_idx;
    logic [INDEX_WIDTH-1:0] instr_idx;
    logic                   fault;
    logic                   accept;
    logic                   mem_we;
    logic [WIDTH-1:0]       cur_word;
    logic [WIDTH-1:0]       merged;
    logic                   unused_instr_bits;

    assign dataReady  = (state_q != ST_WAIT);
    assign accept     = dataReq && dataReady;
    assign req_idx    = req_addr_q[INDEX_WIDTH+1:2];
    assign instr_idx  = instrAddr[INDEX_WIDTH+1:2];
    assign fault      = (req_addr_q[1:0] != 2'b00) ||
                        ((req_addr_q >> (INDEX_WIDTH + 2)) != '0);
    assign cur_word   = mem[req_idx];

    assign unused_instr_bits = ^{instrAddr[ADDR_WIDTH-1:INDEX_WIDTH+2], instrAddr[1:0]};

    assign instrOut   = instr_out_q;
    assign instrValid = instr_valid_q;
    assign dataOut    = data_out_q;
    assign dataValid  = data_valid_q;
    assign dataError  = data_error_q;

    // Byte-lane merge of the captured store data over the currently stored word.
    always_comb begin
        merged = cur_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (req_be_q[i]) begin
                merged[8*i +: 8] = req_wdata_q[8*i +: 8];
            end
        end
    end

    // Next-state logic: fetch port, data FSM, completion and acceptance.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        req_addr_d    = req_addr_q;
        req_write_d   = req_write_q;
        req_be_d      = req_be_q;
        req_wdata_d   = req_wdata_q;
        data_out_d    = data_out_q;
        data_error_d  = data_error_q;
        data_valid_d  = 1'b0;
        mem_we        = 1'b0;
        instr_valid_d = instrReq;
        instr_out_d   = instrReq ? mem[instr_idx] : instr_out_q;

        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = ST_COMPLETE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_COMPLETE: begin
                data_valid_d = 1'b1;
                state_d      = ST_IDLE;
                if (fault) begin
                    data_out_d   = '0;
                    data_error_d = 1'b1;
                end else begin
                    data_error_d = 1'b0;
                    data_out_d   = req_write_q ? merged : cur_word;
                    mem_we       = req_write_q;
                end
            end
            default: ;
        endcase

        // A new request may be taken on the same edge the previous one completes.
        if (accept) begin
            req_addr_d  = address;
            req_write_d = dataWrite;
            req_be_d    = dataByteEn;
            req_wdata_d = dataIn;
            if (DATA_LATENCY == 1) begin
                state_d = ST_COMPLETE;
            end else begin
                state_d = ST_WAIT;
                cnt_d   = LAT_M1;
            end
        end
    end

    // Control and output registers; async reset drops any captured request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            req_addr_q    <= '0;
            req_write_q   <= 1'b0;
            req_be_q      <= '0;
            req_wdata_q   <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            data_error_q  <= 1'b0;
            instr_out_q   <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            req_addr_q    <= req_addr_d;
            req_write_q   <= req_write_d;
            req_be_q      <= req_be_d;
            req_wdata_q   <= req_wdata_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            data_error_q  <= data_error_d;
            instr_out_q   <= instr_out_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // Array write at the store completion edge; fetch on that edge sees old data.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[req_idx] <= merged;
        end
    end

endmodule

// File: tb/tb_datamemory_pipelined.sv
// Bench for datamemory_pipelined: instance 0 at latency 1, instance 1 at latency 4.
module tb_datamemory_pipelined;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic [1:0]       req, wr, ireq, rdy, dv, derr, iv;
    logic [1:0][3:0]  be;
    logic [1:0][31:0] addr, din, iaddr, dout, iout;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    always #5 clk = ~clk;

    datamemory_pipelined #(.DATA_LATENCY(1)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .instrReq(ireq[0]), .instrAddr(iaddr[0]), .instrOut(iout[0]), .instrValid(iv[0]),
        .dataReq(req[0]), .dataReady(rdy[0]), .dataWrite(wr[0]), .dataByteEn(be[0]),
        .address(addr[0]), .dataIn(din[0]), .dataOut(dout[0]), .dataValid(dv[0]),
        .dataError(derr[0])
    );

    datamemory_pipelined #(.DATA_LATENCY(4)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .instrReq(ireq[1]), .instrAddr(iaddr[1]), .instrOut(iout[1]), .instrValid(iv[1]),
        .dataReq(req[1]), .dataReady(rdy[1]), .dataWrite(wr[1]), .dataByteEn(be[1]),
        .address(addr[1]), .dataIn(din[1]), .dataOut(dout[1]), .dataValid(dv[1]),
        .dataError(derr[1])
    );

    // ---------------- behavioural model ----------------
    logic [31:0] mmem   [2][4096];
    bit          mknown [2][4096];
    bit          m_pend [2];
    int          m_due  [2];
    logic        m_pw   [2];
    logic [3:0]  m_pbe  [2];
    logic [31:0] m_pa   [2];
    logic [31:0] m_pd   [2];
    logic        e_rdy  [2];
    logic        e_dv   [2];
    logic        e_err  [2];
    logic        e_iv   [2];
    logic [31:0] e_dout [2];
    logic [31:0] e_iout [2];
    bit          e_dk   [2];
    bit          e_ik   [2];
    int          ecnt = 0;

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = 0;
            e_rdy[k]  = 1'b1;
            e_dv[k]   = 1'b0;
            e_err[k]  = 1'b0;
            e_iv[k]   = 1'b0;
            e_dout[k] = '0;
            e_iout[k] = '0;
            e_dk[k]   = 1;
            e_ik[k]   = 1;
        end
    endtask

    // Response is due lat(k) edges after acceptance; ready unless a response is due later than next edge.
    task automatic model_edge();
        int          idx;
        logic [31:0] w;
        bit          f;
        for (int k = 0; k < 2; k++) begin
            if (ireq[k]) begin
                idx       = int'(iaddr[k][13:2]);
                e_iv[k]   = 1'b1;
                e_iout[k] = mmem[k][idx];
                e_ik[k]   = mknown[k][idx];
            end else begin
                e_iv[k] = 1'b0;
            end
            e_dv[k] = 1'b0;
            if (m_pend[k] && m_due[k] == ecnt) begin
                idx       = int'(m_pa[k][13:2]);
                f         = (m_pa[k][1:0] != 2'b00) || (m_pa[k][31:14] != '0);
                m_pend[k] = 0;
                e_dv[k]   = 1'b1;
                if (f) begin
                    e_err[k]  = 1'b1;
                    e_dout[k] = '0;
                    e_dk[k]   = 1;
                end else begin
                    e_err[k] = 1'b0;
                    if (m_pw[k]) begin
                        w = mmem[k][idx];
                        for (int b = 0; b < 4; b++)
                            if (m_pbe[k][b]) w[8*b +: 8] = m_pd[k][8*b +: 8];
                        mmem[k][idx]   = w;
                        mknown[k][idx] = mknown[k][idx] || (m_pbe[k] == 4'hF);
                    end
                    e_dout[k] = mmem[k][idx];
                    e_dk[k]   = mknown[k][idx];
                end
            end
            if (req[k] && e_rdy[k]) begin
                m_pend[k] = 1;
                m_due[k]  = ecnt + lat(k);
                m_pw[k]   = wr[k];
                m_pbe[k]  = be[k];
                m_pa[k]   = addr[k];
                m_pd[k]   = din[k];
            end
            e_rdy[k] = !(m_pend[k] && m_due[k] > ecnt + 1);
        end
        ecnt++;
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4096; i++) mknown[k][i] = 0;
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_edge();
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                for (int k = 0; k < 2; k++) begin
                    check($sformatf("d%0d.ready", k),  32'(rdy[k]),  32'(e_rdy[k]));
                    check($sformatf("d%0d.dvalid", k), 32'(dv[k]),   32'(e_dv[k]));
                    check($sformatf("d%0d.derr", k),   32'(derr[k]), 32'(e_err[k]));
                    check($sformatf("d%0d.ivalid", k), 32'(iv[k]),   32'(e_iv[k]));
                    if (e_dk[k]) check($sformatf("d%0d.dout", k), dout[k], e_dout[k]);
                    if (e_ik[k]) check($sformatf("d%0d.iout", k), iout[k], e_iout[k]);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int k, input logic r, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
        req[k]  = r;
        wr[k]   = w;
        be[k]   = b;
        addr[k] = a;
        din[k]  = d;
    endtask

    initial begin
        req = '0; wr = '0; ireq = '0; be = '0; addr = '0; din = '0; iaddr = '0;
        reset_n = 1'b0;
        repeat (3) step();
        check("rst.dvalid", 32'(dv[0]), 32'h0);
        check("rst.dout", dout[1], 32'h0);
        reset_n = 1'b1;
        started = 1;

        // Latency 1: store then back-to-back load
        drv(0, 1, 1, 4'hF, 32'h10, 32'hDEADBEEF); step();
        check("A.ready_c0", 32'(rdy[0]), 32'h1);
        drv(0, 1, 0, 4'h0, 32'h10, 32'h0); step();
        check("A.valid_c1", 32'(dv[0]), 32'h1);
        check("A.store_out", dout[0], 32'hDEADBEEF);
        check("A.ready_c1", 32'(rdy[0]), 32'h1);
        drv(0, 0, 0, 4'h0, 32'h0, 32'h0); step();
        check("A.valid_c2", 32'(dv[0]), 32'h1);
        check("A.load_out", dout[0], 32'hDEADBEEF);
        step();
        check("A.valid_c3", 32'(dv[0]), 32'h0);
        check("A.hold", dout[0], 32'hDEADBEEF);

        // Byte enables
        drv(0, 1, 1, 4'hF, 32'h20, 32'h11223344); step();
        drv(0, 0, 0, 4'h0, 32'h0, 32'h0); step();
        drv(0, 1, 1, 4'b0101, 32'h20, 32'hAABBCCDD); step();
        drv(0, 1, 0, 4'h0, 32'h20, 32'h0); step();
        check("B.store_merge", dout[0], 32'h11BB33DD);
        drv(0, 0, 0, 4'h0, 32'h0, 32'h0); step();
        check("B.load", dout[0], 32'h11BB33DD);
        drv(0, 1, 1, 4'h0, 32'h20, 32'hFFFFFFFF); step();
        drv(0, 0, 0, 4'h0, 32'h0, 32'h0); step();
        check("B.be0_out", dout[0], 32'h11BB33DD);
        drv(0, 1, 0, 4'h0, 32'h20, 32'h0); step();
        drv(0, 0, 0, 4'h0, 32'h0, 32'h0); step();
        check("B.be0_load", dout[0], 32'h11BB33DD);

        // Errors
        drv(0, 1, 1, 4'hF, 32'h13, 32'h12345678); step();
        drv(0, 1, 0, 4'h0, 32'h10, 32'h0); step();
        check("C.st_err", 32'(derr[0]), 32'h1);
        check("C.st_dout", dout[0], 32'h0);
        drv(0, 1, 0, 4'h0, 32'h4000, 32'h0); step();
        check("C.ld10", dout[0], 32'hDEADBEEF);
        check("C.ld10_err", 32'(derr[0]), 32'h0);
        drv(0, 0, 0, 4'h0, 32'h0, 32'h0); step();
        check("C.ld4000_err", 32'(derr[0]), 32'h1);
        check("C.ld4000_dout", dout[0], 32'h0);
        step();
        check("C.err_hold", 32'(derr[0]), 32'h1);

        // Fetch/store collision
        drv(0, 1, 1, 4'hF, 32'h30, 32'hCAFEF00D); step();
        drv(0, 0, 0, 4'h0, 32'h0, 32'h0); step();
        drv(0, 1, 1, 4'hF, 32'h30, 32'h0BADC0DE); step();
        drv(0, 0, 0, 4'h0, 32'h0, 32'h0);
        ireq[0] = 1'b1; iaddr[0] = 32'h30; step();
        check("D.old", iout[0], 32'hCAFEF00D);
        check("D.ivalid", 32'(iv[0]), 32'h1);
        step();
        check("D.new", iout[0], 32'h0BADC0DE);
        ireq[0] = 1'b0; step();
        check("D.ivalid0", 32'(iv[0]), 32'h0);
        check("D.ihold", iout[0], 32'h0BADC0DE);

        // Latency 4
        drv(1, 1, 1, 4'hF, 32'h40, 32'h55AA1234); step();
        drv(1, 0, 0, 4'h0, 32'h0, 32'h0);
        repeat (4) step();
        check("E.st_valid", 32'(dv[1]), 32'h1);
        check("E.st_out", dout[1], 32'h55AA1234);
        drv(1, 1, 0, 4'h0, 32'h40, 32'h0); step();
        drv(1, 0, 0, 4'h0, 32'h0, 32'h0);
        check("E.ready_c0", 32'(rdy[1]), 32'h0);
        step();
        check("E.ready_c1", 32'(rdy[1]), 32'h0);
        step();
        check("E.ready_c2", 32'(rdy[1]), 32'h0);
        drv(1, 1, 0, 4'h0, 32'h40, 32'h0); step();
        drv(1, 0, 0, 4'h0, 32'h0, 32'h0);
        check("E.ready_c3", 32'(rdy[1]), 32'h1);
        check("E.valid_c3", 32'(dv[1]), 32'h0);
        step();
        check("E.valid_c4", 32'(dv[1]), 32'h1);
        check("E.load_out", dout[1], 32'h55AA1234);
        for (int c = 5; c < 9; c++) begin
            step();
            check($sformatf("E.novalid_c%0d", c), 32'(dv[1]), 32'h0);
        end

        // Reset in the middle of a latency-4 store
        ireq[1] = 1'b1; iaddr[1] = 32'h40; step();
        check("R.fetch_pre", iout[1], 32'h55AA1234);
        drv(1, 1, 1, 4'hF, 32'h40, 32'hFFFF0000); step();
        drv(1, 0, 0, 4'h0, 32'h0, 32'h0);
        step(); step();
        reset_n = 1'b0;
        #1;
        check("R.dout", dout[1], 32'h0);
        check("R.iout", iout[1], 32'h0);
        check("R.ivalid", 32'(iv[1]), 32'h0);
        check("R.dvalid", 32'(dv[1]), 32'h0);
        check("R.derr0", 32'(derr[0]), 32'h0);
        check("R.iout0", iout[0], 32'h0);
        step(); step();
        reset_n = 1'b1;
        check("R.ready", 32'(rdy[1]), 32'h1);
        drv(1, 1, 0, 4'h0, 32'h40, 32'h0); step();
        drv(1, 0, 0, 4'h0, 32'h0, 32'h0);
        check("R.fetch_post", iout[1], 32'h55AA1234);
        repeat (4) step();
        check("R.load_valid", 32'(dv[1]), 32'h1);
        check("R.load_out", dout[1], 32'h55AA1234);
        ireq[1] = 1'b0;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
